// File: rtl/key_debounce.sv
// key_debounce: per-channel pushbutton conditioner.
// Each raw key is synchronised into the CLOCK_50 domain and filtered by a stability counter.
// A change is accepted only after DEBOUNCE_CYCLES consecutive samples that disagree with
// the debounced level. Each acceptance fires a registered one-cycle press or release pulse.
module key_debounce #(
    parameter int N_KEYS          = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release
);

    localparam int          CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic        ACT_LOW_BIT = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    // Raw level of an idle (released) key; the synchroniser resets to this
    // so reset never looks like a press.
    localparam logic [N_KEYS-1:0] RELEASED = {N_KEYS{ACT_LOW_BIT}};

    logic [N_KEYS-1:0] sync1_q, sync1_d;
    logic [N_KEYS-1:0] sync2_q, sync2_d;
    logic [N_KEYS-1:0] level_q, level_d;
    logic [N_KEYS-1:0] press_q, press_d;
    logic [N_KEYS-1:0] release_q, release_d;
    logic [CW-1:0]     cnt_q [N_KEYS];
    logic [CW-1:0]     cnt_d [N_KEYS];
    logic [N_KEYS-1:0] pressed_s;

    // Synchroniser next state and polarity normalisation (1 = pressed).
    always_comb begin
        sync1_d   = key_in;
        sync2_d   = sync1_q;
        pressed_s = sync2_q ^ {N_KEYS{ACT_LOW_BIT}};
    end

    // Stability counter and acceptance decision, independent per channel.
    always_comb begin
        level_d   = level_q;
        press_d   = {N_KEYS{1'b0}};
        release_d = {N_KEYS{1'b0}};
        for (int k = 0; k < N_KEYS; k++) begin
            cnt_d[k] = {CW{1'b0}};
            if (pressed_s[k] == level_q[k]) begin
                // Agreement wipes any partial credit.
                cnt_d[k] = {CW{1'b0}};
            end else if (cnt_q[k] == CNT_LAST) begin
                // Final disagreeing sample: accept the new level and pulse.
                cnt_d[k]     = {CW{1'b0}};
                level_d[k]   = pressed_s[k];
                press_d[k]   = pressed_s[k];
                release_d[k] = ~pressed_s[k];
            end else begin
                cnt_d[k] = cnt_q[k] + CW'(1);
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1_q   <= RELEASED;
            sync2_q   <= RELEASED;
            level_q   <= {N_KEYS{1'b0}};
            press_q   <= {N_KEYS{1'b0}};
            release_q <= {N_KEYS{1'b0}};
            for (int k = 0; k < N_KEYS; k++) begin
                cnt_q[k] <= {CW{1'b0}};
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int k = 0; k < N_KEYS; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed scenarios plus randomized traffic for key_debounce.
// The reference model accepts a new level once the last DEB normalised samples all disagree
// with the current level.
module tb_key_debounce;

    localparam int DEB = 4;
    localparam int NK  = 2;

    logic          CLOCK_50 = 1'b0;
    logic          reset    = 1'b1;
    logic [NK-1:0] key_in   = 2'b11;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [NK-1:0] m_s1      = 2'b11;
    logic [NK-1:0] m_s2      = 2'b11;
    logic [NK-1:0] m_level   = 2'b00;
    logic [NK-1:0] m_press   = 2'b00;
    logic [NK-1:0] m_release = 2'b00;
    logic          m_hist [NK][DEB];

    key_debounce #(
        .N_KEYS(NK),
        .DEBOUNCE_CYCLES(DEB),
        .ACTIVE_LOW(1)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .key_in(key_in),
        .key_level(key_level),
        .key_press(key_press),
        .key_release(key_release)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Advance the model by one rising edge using the inputs the DUT just sampled.
    task automatic model_edge();
        if (reset) begin
            m_s1      = 2'b11;
            m_s2      = 2'b11;
            m_level   = 2'b00;
            m_press   = 2'b00;
            m_release = 2'b00;
            for (int k = 0; k < NK; k++)
                for (int i = 0; i < DEB; i++)
                    m_hist[k][i] = 1'b0;
        end else begin
            for (int k = 0; k < NK; k++) begin
                logic p;
                logic all_dis;
                p = ~m_s2[k];
                for (int i = DEB - 1; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
                m_hist[k][0] = p;
                all_dis = 1'b1;
                for (int i = 0; i < DEB; i++)
                    if (m_hist[k][i] == m_level[k]) all_dis = 1'b0;
                m_press[k]   = 1'b0;
                m_release[k] = 1'b0;
                if (all_dis) begin
                    m_level[k]   = p;
                    m_press[k]   = p;
                    m_release[k] = ~p;
                end
            end
            m_s2 = m_s1;
            m_s1 = key_in;
        end
    endtask

    // Drive inputs, take one clock edge, update the model, settle for sampling.
    task automatic step(input logic [NK-1:0] k, input logic r);
        key_in = k;
        reset  = r;
        @(posedge CLOCK_50);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(2'b11, 1'b1);
            checks++;
            if ({key_level, key_press, key_release} !== 6'b000000) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=000000", i, {key_level, key_press, key_release});
            end
        end
        for (int i = 0; i < 20; i++) begin
            step(2'b11, 1'b0);
            checks++;
            if ({key_level, key_press, key_release} !== 6'b000000) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=000000", i, {key_level, key_press, key_release});
            end
        end
    endtask

    task automatic test_press();
        int hits;
        int at;
        int other;
        hits = 0; at = -1; other = 0;
        for (int i = 0; i < 9; i++) begin
            step(2'b10, 1'b0);
            checks++;
            if ({key_level, key_press, key_release} !== {m_level, m_press, m_release}) begin
                failures++;
                $display("FAIL press_model cyc=%0d got=%b exp=%b", i, {key_level, key_press, key_release}, {m_level, m_press, m_release});
            end
            if (key_press[0]) begin hits++; at = i; end
            if (key_press[1] || key_release != 2'b00) other++;
        end
        checks++;
        if (hits != 1 || at != 5) begin
            failures++;
            $display("FAIL press_latency got hits=%0d at=%0d exp hits=1 at=5", hits, at);
        end
        checks++;
        if (key_level !== 2'b01) begin
            failures++;
            $display("FAIL press_level got=%b exp=01", key_level);
        end
        checks++;
        if (other != 0) begin
            failures++;
            $display("FAIL press_other got=%0d exp=0", other);
        end
    endtask

    task automatic test_release();
        int hits;
        int at;
        hits = 0; at = -1;
        // Short high glitch while pressed, then back to pressed.
        for (int i = 0; i < 9; i++) begin
            step((i < 3) ? 2'b11 : 2'b10, 1'b0);
            checks++;
            if ({key_level, key_press, key_release} !== {m_level, m_press, m_release}) begin
                failures++;
                $display("FAIL glitch_model cyc=%0d got=%b exp=%b", i, {key_level, key_press, key_release}, {m_level, m_press, m_release});
            end
            if (key_release != 2'b00 || key_level !== 2'b01) hits++;
        end
        checks++;
        if (hits != 0) begin
            failures++;
            $display("FAIL glitch_reject got=%0d exp=0", hits);
        end
        hits = 0;
        for (int i = 0; i < 9; i++) begin
            step(2'b11, 1'b0);
            checks++;
            if ({key_level, key_press, key_release} !== {m_level, m_press, m_release}) begin
                failures++;
                $display("FAIL release_model cyc=%0d got=%b exp=%b", i, {key_level, key_press, key_release}, {m_level, m_press, m_release});
            end
            if (key_release[0]) begin hits++; at = i; end
        end
        checks++;
        if (hits != 1 || at != 5 || key_level !== 2'b00) begin
            failures++;
            $display("FAIL release_latency got hits=%0d at=%0d lvl=%b exp hits=1 at=5 lvl=00", hits, at, key_level);
        end
    endtask

    task automatic test_bounce();
        logic pat [17];
        int hits;
        int at;
        pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        hits = 0; at = -1;
        for (int i = 0; i < 17; i++) begin
            step({1'b1, pat[i]}, 1'b0);
            checks++;
            if ({key_level, key_press, key_release} !== {m_level, m_press, m_release}) begin
                failures++;
                $display("FAIL bounce_model cyc=%0d got=%b exp=%b", i, {key_level, key_press, key_release}, {m_level, m_press, m_release});
            end
            if (key_press != 2'b00) begin hits++; at = i; end
        end
        // Final stable-low run starts at step 7, so the pulse lands on step 12.
        checks++;
        if (hits != 1 || at != 12) begin
            failures++;
            $display("FAIL bounce_latency got hits=%0d at=%0d exp hits=1 at=12", hits, at);
        end
        for (int i = 0; i < 9; i++) step(2'b11, 1'b0);
        checks++;
        if (key_level !== 2'b00) begin
            failures++;
            $display("FAIL bounce_cleanup got=%b exp=00", key_level);
        end
    endtask

    task automatic test_both();
        int hits;
        int at;
        int rel_at;
        hits = 0; at = -1; rel_at = -1;
        for (int i = 0; i < 9; i++) begin
            step(2'b00, 1'b0);
            checks++;
            if ({key_level, key_press, key_release} !== {m_level, m_press, m_release}) begin
                failures++;
                $display("FAIL both_model cyc=%0d got=%b exp=%b", i, {key_level, key_press, key_release}, {m_level, m_press, m_release});
            end
            if (key_press != 2'b00) begin hits++; if (key_press == 2'b11) at = i; end
        end
        checks++;
        if (hits != 1 || at != 5 || key_level !== 2'b11) begin
            failures++;
            $display("FAIL both_press got hits=%0d at=%0d lvl=%b exp hits=1 at=5 lvl=11", hits, at, key_level);
        end
        for (int i = 0; i < 9; i++) begin
            step(2'b11, 1'b0);
            if (key_release == 2'b11) rel_at = i;
        end
        checks++;
        if (rel_at != 5 || key_level !== 2'b00) begin
            failures++;
            $display("FAIL both_release got at=%0d lvl=%b exp at=5 lvl=00", rel_at, key_level);
        end
    endtask

    task automatic test_reset_mid();
        int rel_seen;
        int hits;
        int at;
        rel_seen = 0;
        for (int pass = 0; pass < 2; pass++) begin
            // Pass 0 interrupts a count; pass 1 interrupts an accepted press.
            for (int i = 0; i < 2; i++) begin
                step(2'b01, 1'b0);
                if (key_release != 2'b00) rel_seen++;
            end
            for (int i = 0; i < 2; i++) begin
                step(2'b01, 1'b1);
                checks++;
                if ({key_level, key_press, key_release} !== 6'b000000) begin
                    failures++;
                    $display("FAIL rstmid_zero pass=%0d cyc=%0d got=%b exp=000000", pass, i, {key_level, key_press, key_release});
                end
            end
            hits = 0; at = -1;
            for (int i = 0; i < 9; i++) begin
                step(2'b01, 1'b0);
                checks++;
                if ({key_level, key_press, key_release} !== {m_level, m_press, m_release}) begin
                    failures++;
                    $display("FAIL rstmid_model pass=%0d cyc=%0d got=%b exp=%b", pass, i, {key_level, key_press, key_release}, {m_level, m_press, m_release});
                end
                if (key_press != 2'b00) begin hits++; if (key_press == 2'b10) at = i; end
                if (key_release != 2'b00) rel_seen++;
            end
            checks++;
            if (hits != 1 || at != 5 || key_level !== 2'b10) begin
                failures++;
                $display("FAIL rstmid_press pass=%0d got hits=%0d at=%0d lvl=%b exp hits=1 at=5 lvl=10", pass, hits, at, key_level);
            end
        end
        checks++;
        if (rel_seen != 0) begin
            failures++;
            $display("FAIL rstmid_norelease got=%0d exp=0", rel_seen);
        end
    endtask

    task automatic test_random();
        logic [NK-1:0] k;
        logic          r;
        k = key_in;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < NK; b++)
                if ($urandom_range(0, 5) == 0) k[b] = ~k[b];
            r = ($urandom_range(0, 99) == 0);
            step(k, r);
            checks++;
            if ({key_level, key_press, key_release} !== {m_level, m_press, m_release}) begin
                failures++;
                $display("FAIL random_model cyc=%0d in=%b rst=%b got=%b exp=%b", i, k, r, {key_level, key_press, key_release}, {m_level, m_press, m_release});
            end
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_release();
        test_bounce();
        test_both();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
